// File: rtl/ysyx_23060072_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_mem_arbiter_pkg
// Shared definitions for the IF/LSU memory arbiter:
//   - arb_state_e : sequencer states (idle, request on the bus, awaiting rsp)
//   - ARB_OWNER_* : which requester owns the in-flight transaction
//   - STARVE_W    : width of the IF starvation counter
// ---------------------------------------------------------------------------
package ysyx_23060072_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   localparam logic ARB_OWNER_IF  = 1'b0;
   localparam logic ARB_OWNER_LSU = 1'b1;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/ysyx_23060072_arb_prio.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_arb_prio
// Two-way grant logic with an IF starvation guard. LSU normally wins a
// simultaneous request; after IF_STARVE_MAX consecutive LSU grants that
// were made while IF was waiting, IF wins the next contested cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   grant_en_i    : arbiter is idle and may grant this cycle
//   if_valid_i    : IF requesting
//   lsu_valid_i   : LSU requesting
//   if_grant_o    : IF granted (combinational)
//   lsu_grant_o   : LSU granted (combinational)
// ---------------------------------------------------------------------------
module ysyx_23060072_arb_prio
   import ysyx_23060072_mem_arbiter_pkg::*;
#(
   parameter int IF_STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic grant_en_i,
   input  logic if_valid_i,
   input  logic lsu_valid_i,
   output logic if_grant_o,
   output logic lsu_grant_o
);

   logic [STARVE_W-1:0] starve_cnt_q;
   logic [STARVE_W-1:0] starve_cnt_d;
   logic                if_wins;

   always_comb begin
      // IF wins when uncontested, or when it has waited out the LSU budget.
      if_wins     = if_valid_i &
                    (~lsu_valid_i | (starve_cnt_q == STARVE_W'(IF_STARVE_MAX)));
      if_grant_o  = grant_en_i & if_wins;
      lsu_grant_o = grant_en_i & lsu_valid_i & ~if_wins;

      starve_cnt_d = starve_cnt_q;
      if (lsu_grant_o & if_valid_i) begin
         starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end else if (if_grant_o | lsu_grant_o) begin
         // Either IF was served or nobody was starving it.
         starve_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/ysyx_23060072_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_mem_arbiter
// Shares one memory port between instruction fetch (read-only) and the
// load/store unit. One transaction is in flight at a time; its response is
// routed back to the requester that owns it. Fetches flushed while in
// flight still complete on the bus but their response is swallowed.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   if_req_* / if_addr_i            : fetch request handshake and address
//   if_flush_i                      : cancel any in-flight fetch
//   if_rsp_valid_o / if_rdata_o     : fetch response
//   lsu_req_* / lsu_addr_i / lsu_we_i / lsu_wdata_i / lsu_wstrb_i
//                                   : load/store request
//   lsu_rsp_valid_o / lsu_rdata_o   : load data / store completion
//   mem_req_* / mem_addr_o / mem_we_o / mem_wdata_o / mem_wstrb_o
//                                   : registered memory request
//   mem_rsp_valid_i / mem_rdata_i   : memory response
//   busy_o                          : a transaction is in progress
// ---------------------------------------------------------------------------
module ysyx_23060072_mem_arbiter
   import ysyx_23060072_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int IF_STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_valid_i,
   output logic                if_req_ready_o,
   input  logic [ADDR_W-1:0]   if_addr_i,
   input  logic                if_flush_i,
   output logic                if_rsp_valid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                lsu_req_valid_i,
   output logic                lsu_req_ready_o,
   input  logic [ADDR_W-1:0]   lsu_addr_i,
   input  logic                lsu_we_i,
   input  logic [DATA_W-1:0]   lsu_wdata_i,
   input  logic [DATA_W/8-1:0] lsu_wstrb_i,
   output logic                lsu_rsp_valid_o,
   output logic [DATA_W-1:0]   lsu_rdata_o,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_we_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_wstrb_o,
   input  logic                mem_rsp_valid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                busy_o
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_e          state_q, state_d;
   logic                owner_q, owner_d;
   logic                cancel_q, cancel_d;
   logic                mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;

   logic                is_idle;
   logic                if_grant;
   logic                lsu_grant;
   logic                rsp_fire;
   logic                if_owned;

   assign is_idle  = (state_q == ARB_IDLE);
   assign rsp_fire = (state_q == ARB_RESP) & mem_rsp_valid_i;
   assign if_owned = (owner_q == ARB_OWNER_IF);

   ysyx_23060072_arb_prio #(
      .IF_STARVE_MAX (IF_STARVE_MAX)
   ) u_prio (
      .clk         (clk),
      .rst         (rst),
      .grant_en_i  (is_idle),
      .if_valid_i  (if_req_valid_i),
      .lsu_valid_i (lsu_req_valid_i),
      .if_grant_o  (if_grant),
      .lsu_grant_o (lsu_grant)
   );

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      cancel_d        = cancel_q;
      mem_req_valid_d = mem_req_valid_q;
      addr_d          = addr_q;
      we_d            = we_q;
      wdata_d         = wdata_q;
      wstrb_d         = wstrb_q;

      case (state_q)
         ARB_IDLE: begin
            cancel_d = 1'b0;
            if (lsu_grant) begin
               state_d         = ARB_REQ;
               mem_req_valid_d = 1'b1;
               owner_d         = ARB_OWNER_LSU;
               addr_d          = lsu_addr_i;
               we_d            = lsu_we_i;
               wdata_d         = lsu_wdata_i;
               wstrb_d         = lsu_wstrb_i;
            end else if (if_grant) begin
               // A flush arriving with the accept is not a cancel: the fetch
               // stage simply re-requests after this one drains.
               state_d         = ARB_REQ;
               mem_req_valid_d = 1'b1;
               owner_d         = ARB_OWNER_IF;
               addr_d          = if_addr_i;
               we_d            = 1'b0;
               wdata_d         = '0;
               wstrb_d         = '0;
            end
         end
         ARB_REQ: begin
            if (if_flush_i & if_owned) begin
               cancel_d = 1'b1;
            end
            if (mem_req_ready_i) begin
               state_d         = ARB_RESP;
               mem_req_valid_d = 1'b0;
            end
         end
         ARB_RESP: begin
            if (if_flush_i & if_owned) begin
               cancel_d = 1'b1;
            end
            if (mem_rsp_valid_i) begin
               state_d  = ARB_IDLE;
               cancel_d = 1'b0;
            end
         end
         default: begin
            state_d         = ARB_IDLE;
            mem_req_valid_d = 1'b0;
            cancel_d        = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ARB_IDLE;
         owner_q         <= ARB_OWNER_IF;
         cancel_q        <= 1'b0;
         mem_req_valid_q <= 1'b0;
         addr_q          <= '0;
         we_q            <= 1'b0;
         wdata_q         <= '0;
         wstrb_q         <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         cancel_q        <= cancel_d;
         mem_req_valid_q <= mem_req_valid_d;
         addr_q          <= addr_d;
         we_q            <= we_d;
         wdata_q         <= wdata_d;
         wstrb_q         <= wstrb_d;
      end
   end

   assign if_req_ready_o  = if_grant;
   assign lsu_req_ready_o = lsu_grant;

   // The same-cycle flush term drops a response that lands together with
   // the flush, before cancel has had a chance to register.
   assign if_rsp_valid_o  = rsp_fire & if_owned & ~cancel_q & ~if_flush_i;
   assign lsu_rsp_valid_o = rsp_fire & (owner_q == ARB_OWNER_LSU);
   assign if_rdata_o      = mem_rdata_i;
   assign lsu_rdata_o     = mem_rdata_i;

   assign mem_req_valid_o = mem_req_valid_q;
   assign mem_addr_o      = addr_q;
   assign mem_we_o        = we_q;
   assign mem_wdata_o     = wdata_q;
   assign mem_wstrb_o     = wstrb_q;
   assign busy_o          = ~is_idle;

endmodule
